// File: rtl/alu_muldiv_seq_pkg.sv
// Opcode constants, FSM encoding and opcode-class helpers shared by the sequential ALU.
package alu_muldiv_seq_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SLTU  = 4'b0011;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SLT   = 4'b0111;
    localparam logic [3:0] ALU_MULT  = 4'b1000;
    localparam logic [3:0] ALU_MULTU = 4'b1001;
    localparam logic [3:0] ALU_DIV   = 4'b1010;
    localparam logic [3:0] ALU_DIVU  = 4'b1011;
    localparam logic [3:0] ALU_MFHI  = 4'b1100;
    localparam logic [3:0] ALU_MFLO  = 4'b1101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == ALU_MULT) || (op == ALU_MULTU) || (op == ALU_DIV) || (op == ALU_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [3:0] op);
        return (op == ALU_MULT) || (op == ALU_DIV);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == ALU_DIV) || (op == ALU_DIVU);
    endfunction

endpackage

// File: rtl/alu_muldiv_seq_muldiv.sv
// Iterative unsigned multiply (shift-add) / restoring divide datapath with step counter.
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             div_i,
    input  logic [WIDTH-1:0] a_mag_i,
    input  logic [WIDTH-1:0] b_mag_i,
    output logic [WIDTH-1:0] hi_n_o,
    output logic [WIDTH-1:0] lo_n_o,
    output logic             last_step_o
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, m_q;
    logic [CW-1:0]    cnt_q;
    logic             div_q;
    logic [WIDTH:0]   sum, shifted;
    logic [WIDTH-1:0] rem_sub;
    logic             ge;

    // hi/lo double as {product_hi, product_lo} for mul and {remainder, quotient} for div
    always_comb begin
        sum     = {1'b0, hi_q} + {1'b0, m_q};
        shifted = {hi_q, lo_q[WIDTH-1]};
        ge      = shifted >= {1'b0, m_q};
        rem_sub = shifted[WIDTH-1:0] - m_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (div_q) begin
            hi_d = ge ? rem_sub : shifted[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], ge};
        end else if (lo_q[0]) begin
            hi_d = sum[WIDTH:1];
            lo_d = {sum[0], lo_q[WIDTH-1:1]};
        end else begin
            hi_d = {1'b0, hi_q[WIDTH-1:1]};
            lo_d = {hi_q[0], lo_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            hi_q  <= '0;
            lo_q  <= '0;
            m_q   <= '0;
            cnt_q <= '0;
            div_q <= 1'b0;
        end else if (load_i) begin
            hi_q  <= '0;
            lo_q  <= div_i ? a_mag_i : b_mag_i;
            m_q   <= div_i ? b_mag_i : a_mag_i;
            cnt_q <= '0;
            div_q <= div_i;
        end else if (step_i) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign hi_n_o      = hi_q;
    assign lo_n_o      = lo_q;
    assign last_step_o = step_i && (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/alu_muldiv_seq.sv
// Sequential MIPS EX-stage ALU: single-cycle logic/arith ops plus iterative mul/div into HI/LO.
module alu_muldiv_seq
    import alu_muldiv_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [3:0]       alucontrol_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    state_e           state_q;
    logic [WIDTH-1:0] result_q, hi_q, lo_q, a_orig_q;
    logic             zero_q, busy_q, done_q;
    logic             div_q, neg_q, rneg_q, dz_q;

    logic             accept_md, sgn;
    logic [WIDTH-1:0] a_mag, b_mag, alu_res;
    logic [WIDTH-1:0] raw_hi, raw_lo, q_s, r_s, fix_hi, fix_lo;
    logic [2*WIDTH-1:0] prod, prod_s;
    logic             last_step;

    assign accept_md = (state_q == ST_IDLE) && start_i && is_muldiv(alucontrol_i);
    assign sgn       = is_signed_op(alucontrol_i);
    assign a_mag     = (sgn && a_i[WIDTH-1]) ? -a_i : a_i;
    assign b_mag     = (sgn && b_i[WIDTH-1]) ? -b_i : b_i;

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .load_i      (accept_md),
        .step_i      (state_q == ST_RUN),
        .div_i       (is_div_op(alucontrol_i)),
        .a_mag_i     (a_mag),
        .b_mag_i     (b_mag),
        .hi_n_o      (raw_hi),
        .lo_n_o      (raw_lo),
        .last_step_o (last_step)
    );

    always_comb begin
        alu_res = '0;
        case (alucontrol_i)
            ALU_AND:  alu_res = a_i & b_i;
            ALU_OR:   alu_res = a_i | b_i;
            ALU_ADD:  alu_res = a_i + b_i;
            ALU_SUB:  alu_res = a_i - b_i;
            ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a_i) < $signed(b_i)};
            ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, a_i < b_i};
            ALU_MFHI: alu_res = hi_q;
            ALU_MFLO: alu_res = lo_q;
            default:  alu_res = '0;
        endcase
    end

    // Sign fix-up of the unsigned magnitude result; divide-by-zero returns the raw dividend
    always_comb begin
        prod   = {raw_hi, raw_lo};
        prod_s = neg_q ? -prod : prod;
        q_s    = neg_q ? -raw_lo : raw_lo;
        r_s    = rneg_q ? -raw_hi : raw_hi;
        fix_hi = prod_s[2*WIDTH-1:WIDTH];
        fix_lo = prod_s[WIDTH-1:0];
        if (div_q) begin
            fix_hi = dz_q ? a_orig_q : r_s;
            fix_lo = dz_q ? '1 : q_s;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            zero_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            a_orig_q <= '0;
            div_q    <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i && is_muldiv(alucontrol_i)) begin
                        state_q  <= ST_RUN;
                        busy_q   <= 1'b1;
                        a_orig_q <= a_i;
                        div_q    <= is_div_op(alucontrol_i);
                        neg_q    <= sgn && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                        rneg_q   <= sgn && a_i[WIDTH-1];
                        dz_q     <= (b_i == '0);
                    end else if (start_i) begin
                        result_q <= alu_res;
                        zero_q   <= (alu_res == '0);
                        done_q   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (last_step) state_q <= ST_FIX;
                end
                ST_FIX: begin
                    hi_q     <= fix_hi;
                    lo_q     <= fix_lo;
                    result_q <= fix_lo;
                    zero_q   <= (fix_lo == '0);
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign result_o = result_q;
    assign zero_o   = zero_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign hi_o     = hi_q;
    assign lo_o     = lo_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed vector table plus hand sequences for busy-ignore, done-cycle issue and mid-op reset.
module tb_alu_muldiv_seq;
    import alu_muldiv_seq_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [3:0]   alucontrol;
    logic [W-1:0] a, b, result, hi, lo;
    logic         zero, busy, done;

    int n_chk = 0;
    int err_cnt = 0;

    alu_muldiv_seq #(.WIDTH(W)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .start_i      (start),
        .alucontrol_i (alucontrol),
        .a_i          (a),
        .b_i          (b),
        .result_o     (result),
        .zero_o       (zero),
        .busy_o       (busy),
        .done_o       (done),
        .hi_o         (hi),
        .lo_o         (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         z;
        logic         hl;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Issue one op from a negedge; returns edges from the start edge to the done edge
    // inclusive and the number of sampled cycles with busy high.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                         output int edges, output int busy_cyc);
        start = 1'b1; alucontrol = op; a = av; b = bv;
        @(posedge clk);
        edges = 1;
        busy_cyc = 0;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); alucontrol = 4'($urandom);
        while (!done && edges < 40) begin
            if (busy) busy_cyc++;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
    endtask

    initial begin
        int edges, bcyc, cnt;
        reset = 1'b1; start = 1'b0; alucontrol = '0; a = '0; b = '0;

        vecs.push_back('{"add",      ALU_ADD,   8'd200, 8'd100, 8'd44, 1'b0, 1'b0, 8'h00, 8'h00});
        vecs.push_back('{"sub",      ALU_SUB,   8'd25,  8'd25,  8'd0,  1'b1, 1'b0, 8'h00, 8'h00});
        vecs.push_back('{"slt",      ALU_SLT,   8'hF0,  8'd3,   8'd1,  1'b0, 1'b0, 8'h00, 8'h00});
        vecs.push_back('{"sltu",     ALU_SLTU,  8'hF0,  8'd3,   8'd0,  1'b1, 1'b0, 8'h00, 8'h00});
        vecs.push_back('{"and",      ALU_AND,   8'hF0,  8'h3C,  8'h30, 1'b0, 1'b0, 8'h00, 8'h00});
        vecs.push_back('{"or",       ALU_OR,    8'hF0,  8'h0C,  8'hFC, 1'b0, 1'b0, 8'h00, 8'h00});
        vecs.push_back('{"undef",    4'b0100,   8'd5,   8'd9,   8'h00, 1'b1, 1'b0, 8'h00, 8'h00});
        vecs.push_back('{"mult",     ALU_MULT,  8'hFD,  8'd7,   8'hEB, 1'b0, 1'b1, 8'hFF, 8'hEB});
        vecs.push_back('{"multu",    ALU_MULTU, 8'hFD,  8'd7,   8'hEB, 1'b0, 1'b1, 8'h06, 8'hEB});
        vecs.push_back('{"div",      ALU_DIV,   8'hF9,  8'd2,   8'hFD, 1'b0, 1'b1, 8'hFF, 8'hFD});
        vecs.push_back('{"divu_dz",  ALU_DIVU,  8'd9,   8'd0,   8'hFF, 1'b0, 1'b1, 8'h09, 8'hFF});
        vecs.push_back('{"mfhi",     ALU_MFHI,  8'd0,   8'd0,   8'h09, 1'b0, 1'b1, 8'h09, 8'hFF});
        vecs.push_back('{"div_ovf",  ALU_DIV,   8'h80,  8'hFF,  8'h80, 1'b0, 1'b1, 8'h00, 8'h80});
        vecs.push_back('{"div_negb", ALU_DIV,   8'h07,  8'hFE,  8'hFD, 1'b0, 1'b1, 8'h01, 8'hFD});
        vecs.push_back('{"mult_mn",  ALU_MULT,  8'h80,  8'h80,  8'h00, 1'b1, 1'b1, 8'h40, 8'h00});
        vecs.push_back('{"multu_ff", ALU_MULTU, 8'hFF,  8'hFF,  8'h01, 1'b0, 1'b1, 8'hFE, 8'h01});
        vecs.push_back('{"div_dz",   ALU_DIV,   8'hF9,  8'h00,  8'hFF, 1'b0, 1'b1, 8'hF9, 8'hFF});
        vecs.push_back('{"mflo",     ALU_MFLO,  8'd0,   8'd0,   8'hFF, 1'b0, 1'b0, 8'h00, 8'h00});
        vecs.push_back('{"divu",     ALU_DIVU,  8'd200, 8'd7,   8'h1C, 1'b0, 1'b1, 8'h04, 8'h1C});
        vecs.push_back('{"mfhi2",    ALU_MFHI,  8'd0,   8'd0,   8'h04, 1'b0, 1'b0, 8'h00, 8'h00});

        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_result", result, 0);
        chk("rst_zero", zero, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);

        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, edges, bcyc);
            chk({vecs[i].name, "_result"}, result, vecs[i].res);
            chk({vecs[i].name, "_zero"}, zero, vecs[i].z);
            chk({vecs[i].name, "_done"}, done, 1);
            chk({vecs[i].name, "_edges"}, edges, is_muldiv(vecs[i].op) ? W + 2 : 1);
            chk({vecs[i].name, "_busycyc"}, bcyc, is_muldiv(vecs[i].op) ? W + 1 : 0);
            if (vecs[i].hl) begin
                chk({vecs[i].name, "_hi"}, hi, vecs[i].hi);
                chk({vecs[i].name, "_lo"}, lo, vecs[i].lo);
            end
        end

        // done is a single-cycle pulse
        @(posedge clk); @(negedge clk);
        chk("done_pulse_width", done, 0);

        // MULT 3*4 with an ADD request held during busy, then MFLO issued in the done cycle
        start = 1'b1; alucontrol = ALU_MULT; a = 8'd3; b = 8'd4;
        @(posedge clk); @(negedge clk);
        alucontrol = ALU_ADD; a = 8'd1; b = 8'd1;
        cnt = 0;
        while (!done && cnt < 40) begin
            @(posedge clk); @(negedge clk);
            cnt++;
        end
        chk("m34_done", done, 1);
        chk("m34_lo", lo, 8'd12);
        chk("m34_hi", hi, 8'd0);
        chk("m34_result", result, 8'd12);
        alucontrol = ALU_MFLO;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        chk("mflo_done", done, 1);
        chk("mflo_result", result, 8'd12);
        chk("mflo_busy", busy, 0);

        // Reset arriving on the 4th edge after a DIV starts discards it
        @(negedge clk);
        start = 1'b1; alucontrol = ALU_DIV; a = 8'd100; b = 8'd7;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_hi", hi, 0);
        chk("mid_rst_lo", lo, 0);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_zero", zero, 1);
        cnt = 0;
        for (int k = 0; k < 14; k++) begin
            if (done || busy) cnt++;
            @(posedge clk); @(negedge clk);
        end
        chk("mid_rst_no_done", cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, err_cnt);
        $finish;
    end

endmodule
